// File: rtl/tl_pkg.sv
// Shared types and helpers for the two-direction traffic-light sequencer.
package tl_pkg;

    localparam int unsigned LIGHT_W = 3;

    typedef enum logic [2:0] {
        RED_A  = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        RED_B  = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5
    } tl_state_e;

    localparam logic [LIGHT_W-1:0] LT_RED = 3'b100;
    localparam logic [LIGHT_W-1:0] LT_YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] LT_GRN = 3'b001;

    // Phase length in ticks for a given state
    function automatic int unsigned phase_dur(tl_state_e s, int unsigned g_time,
                                              int unsigned y_time, int unsigned r_time);
        case (s)
            NS_GRN, EW_GRN: return g_time;
            NS_YEL, EW_YEL: return y_time;
            default:        return r_time;
        endcase
    endfunction

    function automatic tl_state_e next_phase(tl_state_e s);
        case (s)
            RED_A:   return NS_GRN;
            NS_GRN:  return NS_YEL;
            NS_YEL:  return RED_B;
            RED_B:   return EW_GRN;
            EW_GRN:  return EW_YEL;
            default: return RED_A;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Control/status bundle between the sequencer and its environment.
interface traffic_light_ctrl_if #(
    parameter int unsigned CW = 7
);
    logic                         en;
    logic                         tick;
    logic                         req_ns;
    logic                         req_ew;
    logic [tl_pkg::LIGHT_W-1:0]   ns_light;
    logic [tl_pkg::LIGHT_W-1:0]   ew_light;
    logic [CW-1:0]                remain;
    logic                         phase_done;

    modport master (
        output en, tick, req_ns, req_ew,
        input  ns_light, ew_light, remain, phase_done
    );

    modport slave (
        input  en, tick, req_ns, req_ew,
        output ns_light, ew_light, remain, phase_done
    );
endinterface

// File: rtl/tl_phase_timer.sv
// Shared phase down-counter: load has priority, decrements on tick, saturates at zero.
module tl_phase_timer #(
    parameter int unsigned CW      = 7,
    parameter int unsigned RST_VAL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          tick_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Zero flag registered alongside the count so it always matches cnt_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CW'(RST_VAL);
            zero_q <= (RST_VAL == 0);
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW traffic-light sequencer: phase FSM, demand latches and lamp decode
// around a single shared phase timer.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned G_TIME = 30,
    parameter int unsigned G_MIN  = 10,
    parameter int unsigned Y_TIME = 3,
    parameter int unsigned R_TIME = 2,
    parameter int unsigned CW     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  ctrl
);

    // Early exit is allowed once at least G_MIN ticks of green have elapsed
    localparam logic [CW-1:0] EXIT_TH = CW'(G_TIME - G_MIN);

    tl_state_e     state_q, state_d;
    logic          pend_ns_q, pend_ns_d;
    logic          pend_ew_q, pend_ew_d;
    logic          phase_done_q, phase_done_d;
    logic          step;
    logic          early_exit;
    logic          illegal;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    assign step = ctrl.en && ctrl.tick;

    tl_phase_timer #(
        .CW      (CW),
        .RST_VAL (R_TIME - 1)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_i     (step),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RED_A;
            pend_ns_q    <= 1'b0;
            pend_ew_q    <= 1'b0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_ns_q    <= pend_ns_d;
            pend_ew_q    <= pend_ew_d;
            phase_done_q <= phase_done_d;
        end
    end

    // Next-state, timer reload and demand latches
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        load_val     = CW'(R_TIME - 1);
        phase_done_d = 1'b0;
        early_exit   = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            NS_GRN:                      early_exit = pend_ew_q && (cnt <= EXIT_TH);
            EW_GRN:                      early_exit = pend_ns_q && (cnt <= EXIT_TH);
            RED_A, NS_YEL, RED_B, EW_YEL: early_exit = 1'b0;
            default:                     illegal    = 1'b1;
        endcase

        if (illegal) begin
            state_d = RED_A;
            load    = 1'b1;
        end else if (step && (cnt_zero || early_exit)) begin
            state_d      = next_phase(state_q);
            load         = 1'b1;
            load_val     = CW'(phase_dur(state_d, G_TIME, Y_TIME, R_TIME) - 1);
            phase_done_d = 1'b1;
        end

        // Entry into a direction's own green serves its demand, even a same-cycle request
        pend_ns_d = pend_ns_q;
        if ((state_d == NS_GRN) && (state_q != NS_GRN)) begin
            pend_ns_d = 1'b0;
        end else if (ctrl.req_ns && (state_q != NS_GRN)) begin
            pend_ns_d = 1'b1;
        end

        pend_ew_d = pend_ew_q;
        if ((state_d == EW_GRN) && (state_q != EW_GRN)) begin
            pend_ew_d = 1'b0;
        end else if (ctrl.req_ew && (state_q != EW_GRN)) begin
            pend_ew_d = 1'b1;
        end
    end

    // Lamp decode from the state register; anything unexpected shows all red
    always_comb begin
        ctrl.ns_light = LT_RED;
        ctrl.ew_light = LT_RED;
        case (state_q)
            NS_GRN:  ctrl.ns_light = LT_GRN;
            NS_YEL:  ctrl.ns_light = LT_YEL;
            EW_GRN:  ctrl.ew_light = LT_GRN;
            EW_YEL:  ctrl.ew_light = LT_YEL;
            default: ctrl.ns_light = LT_RED;
        endcase
    end

    assign ctrl.remain     = cnt + CW'(1);
    assign ctrl.phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a phase-level model predicts every cycle.
module tb_traffic_light_ctrl;
    import tl_pkg::*;

    localparam int unsigned G_TIME = 30;
    localparam int unsigned G_MIN  = 10;
    localparam int unsigned Y_TIME = 3;
    localparam int unsigned R_TIME = 2;
    localparam int unsigned CW     = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_light_ctrl_if #(.CW(CW)) bus ();

    traffic_light_ctrl #(
        .G_TIME (G_TIME),
        .G_MIN  (G_MIN),
        .Y_TIME (Y_TIME),
        .R_TIME (R_TIME),
        .CW     (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    typedef struct {
        logic [2:0]    ns;
        logic [2:0]    ew;
        logic [CW-1:0] rem;
        logic          pd;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Model: phase index 0..5, ticks left, ticks consumed in phase, demand latches
    int unsigned dur[6]    = '{R_TIME, G_TIME, Y_TIME, R_TIME, G_TIME, Y_TIME};
    logic [2:0]  ns_tab[6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0]  ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    int m_ph, m_left, m_tk;
    bit m_pns, m_pew, m_pd;

    // Observations taken from the DUT outputs only
    int            obs_cnt, obs_len, pd_total;
    logic [CW-1:0] obs_rem;
    logic [2:0]    obs_ns, obs_ew;

    task automatic model_reset();
        m_ph = 0; m_left = R_TIME; m_tk = 0;
        m_pns = 0; m_pew = 0; m_pd = 0;
        sb.delete();
        obs_cnt = 0;
    endtask

    task automatic model_step(input bit en, input bit tk, input bit rn, input bit re);
        bit adv = 0;
        int nx;
        if (en && tk) begin
            m_tk++;
            if (m_left == 1) adv = 1;
            else if (m_ph == 1 && m_pew && m_tk >= int'(G_MIN)) adv = 1;
            else if (m_ph == 4 && m_pns && m_tk >= int'(G_MIN)) adv = 1;
        end
        nx = adv ? (m_ph + 1) % 6 : m_ph;
        if (nx == 1 && m_ph != 1) m_pns = 0;
        else if (rn && m_ph != 1) m_pns = 1;
        if (nx == 4 && m_ph != 4) m_pew = 0;
        else if (re && m_ph != 4) m_pew = 1;
        if (adv) begin
            m_ph = nx; m_left = int'(dur[nx]); m_tk = 0;
        end else if (en && tk) begin
            m_left--;
        end
        m_pd = adv;
    endtask

    task automatic cycle(input bit en, input bit tk, input bit rn, input bit re);
        exp_t e;
        logic [2:0]    pns, pew;
        logic [CW-1:0] prem;
        bus.en = en; bus.tick = tk; bus.req_ns = rn; bus.req_ew = re;
        pns = bus.ns_light; pew = bus.ew_light; prem = bus.remain;
        model_step(en, tk, rn, re);
        e.ns = ns_tab[m_ph]; e.ew = ew_tab[m_ph]; e.rem = CW'(m_left); e.pd = m_pd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.ns_light !== e.ns) begin
            failures++;
            $display("FAIL ns_light t=%0t got=%b exp=%b", $time, bus.ns_light, e.ns);
        end
        checks++;
        if (bus.ew_light !== e.ew) begin
            failures++;
            $display("FAIL ew_light t=%0t got=%b exp=%b", $time, bus.ew_light, e.ew);
        end
        checks++;
        if (bus.remain !== e.rem) begin
            failures++;
            $display("FAIL remain t=%0t got=%0d exp=%0d", $time, bus.remain, e.rem);
        end
        checks++;
        if (bus.phase_done !== e.pd) begin
            failures++;
            $display("FAIL phase_done t=%0t got=%b exp=%b", $time, bus.phase_done, e.pd);
        end
        if (en && tk) obs_cnt++;
        if (bus.phase_done === 1'b1) begin
            obs_len = obs_cnt; obs_rem = prem; obs_ns = pns; obs_ew = pew;
            obs_cnt = 0; pd_total++;
        end
    endtask

    // One time unit: three idle clocks then a tick clock
    task automatic tickp(input bit rn, input bit re, input bit hold);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, hold & rn, hold & re);
        cycle(1'b1, 1'b1, rn, re);
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (m_ph != target && n < 200) begin
            tickp(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (m_ph != target) begin
            failures++;
            $display("FAIL run_until phase got=%0d exp=%0d", m_ph, target);
        end
    endtask

    task automatic finish_phase();
        int start = m_ph;
        int n = 0;
        while (m_ph == start && n < 200) begin
            tickp(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic check_len(input string name, input int exp_len);
        checks++;
        if (obs_len !== exp_len) begin
            failures++;
            $display("FAIL %s phase_len got=%0d exp=%0d", name, obs_len, exp_len);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ns_light !== LT_RED || bus.ew_light !== LT_RED) begin
            failures++;
            $display("FAIL reset_lights got=%b/%b exp=100/100", bus.ns_light, bus.ew_light);
        end
        checks++;
        if (bus.remain !== CW'(R_TIME)) begin
            failures++;
            $display("FAIL reset_remain got=%0d exp=%0d", bus.remain, R_TIME);
        end
        checks++;
        if (bus.phase_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_phase_done got=%b exp=0", bus.phase_done);
        end
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fixed_cycle();
        int pd0 = pd_total;
        for (int p = 0; p < 6; p++) begin
            if (p == 1) begin
                checks++;
                if (bus.remain !== CW'(G_TIME)) begin
                    failures++;
                    $display("FAIL ns_grn_entry_remain got=%0d exp=%0d", bus.remain, G_TIME);
                end
            end
            finish_phase();
            check_len("fixed", int'(dur[p]));
            checks++;
            if (obs_ns !== ns_tab[p] || obs_ew !== ew_tab[p]) begin
                failures++;
                $display("FAIL fixed_lights p=%0d got=%b/%b exp=%b/%b", p, obs_ns, obs_ew, ns_tab[p], ew_tab[p]);
            end
        end
        checks++;
        if (pd_total - pd0 !== 6) begin
            failures++;
            $display("FAIL phase_done_count got=%0d exp=6", pd_total - pd0);
        end
    endtask

    task automatic test_early_exit();
        run_until(1);
        tickp(1'b0, 1'b0, 1'b0);
        tickp(1'b0, 1'b0, 1'b0);
        tickp(1'b0, 1'b1, 1'b0);
        finish_phase();
        check_len("early_green", int'(G_MIN));
        checks++;
        if (obs_rem !== CW'(G_TIME - G_MIN + 1)) begin
            failures++;
            $display("FAIL early_exit_remain got=%0d exp=%0d", obs_rem, G_TIME - G_MIN + 1);
        end
        finish_phase();
        check_len("early_yellow", int'(Y_TIME));
        finish_phase();
        check_len("early_allred", int'(R_TIME));
        finish_phase();
        check_len("ew_after_served", int'(G_TIME));
    endtask

    task automatic test_late_req();
        run_until(1);
        repeat (24) tickp(1'b0, 1'b0, 1'b0);
        tickp(1'b0, 1'b1, 1'b0);
        finish_phase();
        check_len("late_green", 26);
    endtask

    task automatic test_freeze();
        run_until(2);
        tickp(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, (i % 4) == 3, 1'b0, 1'b0);
        checks++;
        if (bus.remain !== CW'(Y_TIME - 1) || bus.ns_light !== LT_YEL || bus.ew_light !== LT_RED) begin
            failures++;
            $display("FAIL freeze got rem=%0d ns=%b ew=%b exp rem=%0d ns=010 ew=100",
                     bus.remain, bus.ns_light, bus.ew_light, Y_TIME - 1);
        end
        finish_phase();
        check_len("frozen_yellow", int'(Y_TIME));
    endtask

    task automatic test_ignore_own();
        int n = 0;
        run_until(1);
        while (m_ph == 1 && n < 200) begin
            tickp(1'b1, 1'b0, 1'b1);
            n++;
        end
        check_len("ns_held_green", int'(G_TIME));
        finish_phase();
        finish_phase();
        finish_phase();
        check_len("ew_no_demand", int'(G_TIME));
        n = 0;
        while (m_ph == 5 && n < 200) begin
            tickp(m_left == 1, 1'b0, 1'b0);
            n++;
        end
        finish_phase();
        finish_phase();
        check_len("ns_green_served", int'(G_TIME));
        finish_phase();
        finish_phase();
        finish_phase();
        check_len("ew_after_ns_served", int'(G_TIME));
    endtask

    task automatic test_reset_mid();
        run_until(4);
        tickp(1'b1, 1'b0, 1'b0);
        repeat (3) tickp(1'b0, 1'b0, 1'b0);
        bus.tick = 1'b0; bus.req_ns = 1'b0; bus.req_ew = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ns_light !== LT_RED || bus.ew_light !== LT_RED || bus.remain !== CW'(R_TIME)) begin
            failures++;
            $display("FAIL async_reset got ns=%b ew=%b rem=%0d exp 100/100 rem=%0d",
                     bus.ns_light, bus.ew_light, bus.remain, R_TIME);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 6; p++) begin
            finish_phase();
            check_len("after_reset", int'(dur[p]));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.tick = 1'b0; bus.req_ns = 1'b0; bus.req_ew = 1'b0;
        pd_total = 0; obs_len = 0; obs_rem = '0; obs_ns = '0; obs_ew = '0;
        test_reset();
        test_fixed_cycle();
        test_early_exit();
        test_late_req();
        test_freeze();
        test_ignore_own();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-direction (NS/EW) traffic-light sequencer that owns a single shared phase down-counter and schedules it between the two approaches.
Advanced by a one-cycle `tick` enable, e.g. the 1-per-period `ra` pulse of a cascaded modulo counter.
Honours demand requests from either direction, with a guaranteed minimum green.
Drives lamp outputs and a remaining-time value for a countdown display.

Parameters:
G_TIME, 30, green phase length in ticks (1..2^CW-1)
G_MIN, 10, minimum green ticks before early exit on opposing demand (1..G_TIME)
Y_TIME, 3, yellow phase length in ticks (>=1)
R_TIME, 2, all-red clearance length in ticks (>=1)
CW, 7, phase counter / remain width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
en  in  1  1 = run; 0 = freeze state and counter (ticks ignored)
tick  in  1  one-cycle time-base pulse; one tick = one time unit
req_ns  in  1  demand from NS approach (level or pulse)
req_ew  in  1  demand from EW approach (level or pulse)
ns_light  out  3  {red,yellow,green} one-hot for NS
ew_light  out  3  {red,yellow,green} one-hot for EW
remain  out  CW  ticks left in current phase, = cnt+1
phase_done  out  1  one-cycle registered pulse in the cycle after any phase change

Behaviour:
- States, in fixed cyclic order: RED_A -> NS_GRN -> NS_YEL -> RED_B -> EW_GRN -> EW_YEL -> RED_A.
- Durations: RED_A and RED_B = R_TIME; NS_GRN and EW_GRN = G_TIME; NS_YEL and EW_YEL = Y_TIME.
- Reset (async, immediate):
  - state=RED_A, cnt=R_TIME-1, pend_ns=0, pend_ew=0, phase_done=0.
  - Lights both red (3'b100), remain=R_TIME.
- On entry to any state, cnt loads DUR-1 in the same edge as the state change.
- Each edge with en=1 and tick=1:
  - if cnt==0 or early_exit: advance to the next state, reload cnt, and set phase_done=1 on that edge (visible next cycle).
  - else: cnt <= cnt-1.
- Edges with tick=0 or en=0: state and cnt unchanged, phase_done=0.
- early_exit applies only in green:
  - NS_GRN: pend_ew=1 and cnt <= G_TIME-G_MIN.
  - EW_GRN: pend_ns=1 and cnt <= G_TIME-G_MIN.
  - Result: a green lasts at least G_MIN ticks and at most G_TIME ticks.
  - Yellow and all-red phases are never shortened.
- Demand latches:
  - pend_ew is set by req_ew=1 in any state except EW_GRN, and cleared on the edge entering EW_GRN. pend_ns is symmetric.
  - A request in the same cycle as entry to its own green: clear wins (treated as served).
  - A request during its own green is ignored.
  - Latching is independent of en and tick.
- No demand present: fixed-time cycling continues; the controller never rests in green.
- Lights are a combinational decode of the state register only:
  - NS_GRN: ns=001, ew=100.
  - NS_YEL: ns=010, ew=100.
  - EW_GRN: ns=100, ew=001.
  - EW_YEL: ns=100, ew=010.
  - RED_A, RED_B: both 100.
- Safety: no state may ever present green or yellow on both directions. An illegal state encoding recovers to RED_A with cnt=R_TIME-1.
- Width rule: remain = cnt+1, computed in CW bits; parameters guarantee no overflow.
- rst mid-phase: aborts immediately to the reset values; pending demands are lost.

Decomposition:
- Package tl_pkg holds:
  - the phase state enum (3-bit encoding);
  - light constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001;
  - a function returning phase duration per state.
- One natural sub-module, tl_phase_timer: CW-bit down-counter with load/value/tick inputs and a zero flag. The FSM and demand latches stay in traffic_light_ctrl.

Test Plan:
- Reset, then defaults with a tick every 4 clk, en=1, no requests -> sequence of light pairs for exactly 2/30/3/2/30/3 ticks, repeating; phase_done pulses 6 times per cycle; remain counts 30..1 in NS_GRN.
- req_ew pulsed at the 3rd tick of NS_GRN -> NS_GRN exits on the 10th tick (remain=21 at exit), then 3 ticks yellow and 2 all-red into EW_GRN; pend_ew clears on that entry.
- req_ew pulsed at the 25th tick of NS_GRN -> exits on the next tick (26 ticks of green total).
- en=0 for 50 clk mid-NS_YEL with ticks running -> state, remain and lights frozen; resumes the remaining yellow count exactly when en=1.
- req_ns held high throughout NS_GRN, and asserted on the EW_YEL->RED_A edge -> ignored during NS_GRN; latched in RED_A, cleared on NS_GRN entry; no early exit in the next EW_GRN unless re-requested.
- rst asserted asynchronously mid-EW_GRN (between clk edges) -> outputs immediately both red, remain=2, pending cleared; normal sequence restarts from RED_A.
